// File: rtl/arbitro_compuerta_pkg.sv
// Shared types for the parking gate arbiter: FSM state encodings and lane codes.
package arbitro_compuerta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ABIERTO_ENT = 2'd1,
    ST_ABIERTO_SAL = 2'd2,
    ST_CERRANDO    = 2'd3
  } estado_t;

  typedef enum logic {
    LANE_ENT = 1'b0,
    LANE_SAL = 1'b1
  } lane_t;

endpackage

// File: rtl/arbitro_compuerta_if.sv
// Lane/gate signal bundle. Requests are levels held until granted or withdrawn;
// a grant (concedido_x) holds until a paso_vehiculo pulse or expiry, and abrir/cerrar/timeout are one-cycle pulses.
interface arbitro_compuerta_if #(
  parameter int CNT_W = 4
);
  logic             sol_entrada;
  logic             sol_salida;
  logic             paso_vehiculo;
  logic             concedido_entrada;
  logic             concedido_salida;
  logic             abrir_compuerta;
  logic             cerrar_compuerta;
  logic             timeout;
  logic [CNT_W-1:0] ocupacion;
  logic             lleno;

  modport master (
    output sol_entrada, sol_salida, paso_vehiculo,
    input  concedido_entrada, concedido_salida, abrir_compuerta,
    input  cerrar_compuerta, timeout, ocupacion, lleno
  );

  modport slave (
    input  sol_entrada, sol_salida, paso_vehiculo,
    output concedido_entrada, concedido_salida, abrir_compuerta,
    output cerrar_compuerta, timeout, ocupacion, lleno
  );
endinterface

// File: rtl/arbitro_compuerta_contador.sv
// contador_ocupacion: saturating up/down occupancy counter; lleno is registered with the count.
module contador_ocupacion #(
  parameter int CAPACIDAD = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] ocupacion,
  output logic             lleno
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACIDAD);

  logic [CNT_W-1:0] siguiente;

  always_comb begin
    siguiente = ocupacion;
    if (inc && !dec && ocupacion != CAP)
      siguiente = ocupacion + 1'b1;
    else if (dec && !inc && ocupacion != '0)
      siguiente = ocupacion - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ocupacion <= '0;
      lleno     <= 1'b0;
    end else begin
      ocupacion <= siguiente;
      lleno     <= (siguiente == CAP);
    end
  end
endmodule

// File: rtl/arbitro_compuerta.sv
// Single-gate arbiter: grants the shared gate to entry or exit lane, times out idle grants.
// Build option ARB_PRIO_SALIDA_EN: exit always beats entry instead of round-robin.
module arbitro_compuerta
  import arbitro_compuerta_pkg::*;
#(
  parameter int CAPACIDAD = 8,
  parameter int CNT_W     = 4,
  parameter int T_ESPERA  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  arbitro_compuerta_if.slave    bus,
  output estado_t               estado_dbg
);
  localparam int TW = $clog2(T_ESPERA);

  estado_t       estado;
  logic [TW-1:0] timer;
  logic          conc_ent, conc_sal, abrir, cerrar, tout;
  logic          elig_ent, elig_sal, conceder_ent, conceder_sal;
  logic          expira, inc, dec;
  logic [CNT_W-1:0] ocup;
  logic          lleno;

  assign elig_ent = bus.sol_entrada && !lleno;
  assign elig_sal = bus.sol_salida;
  assign expira   = (timer == TW'(T_ESPERA - 1));

`ifdef ARB_PRIO_SALIDA_EN
  assign conceder_sal = elig_sal;
  assign conceder_ent = elig_ent && !elig_sal;
`else
  lane_t ultimo;
  // On a tie the lane not served last wins; reset leaves "salida" so entry wins first.
  assign conceder_ent = elig_ent && (!elig_sal || ultimo == LANE_SAL);
  assign conceder_sal = elig_sal && !conceder_ent;
`endif

  assign inc = (estado == ST_ABIERTO_ENT) && bus.paso_vehiculo;
  assign dec = (estado == ST_ABIERTO_SAL) && bus.paso_vehiculo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado   <= ST_IDLE;
      timer    <= '0;
      conc_ent <= 1'b0;
      conc_sal <= 1'b0;
      abrir    <= 1'b0;
      cerrar   <= 1'b0;
      tout     <= 1'b0;
`ifndef ARB_PRIO_SALIDA_EN
      ultimo   <= LANE_SAL;
`endif
    end else begin
      abrir  <= 1'b0;
      cerrar <= 1'b0;
      tout   <= 1'b0;
      case (estado)
        ST_IDLE: begin
          timer <= '0;
          if (conceder_ent) begin
            estado   <= ST_ABIERTO_ENT;
            conc_ent <= 1'b1;
            abrir    <= 1'b1;
          end else if (conceder_sal) begin
            estado   <= ST_ABIERTO_SAL;
            conc_sal <= 1'b1;
            abrir    <= 1'b1;
          end
        end
        ST_ABIERTO_ENT, ST_ABIERTO_SAL: begin
          // A pass on the expiry cycle counts as a pass, not a timeout.
          if (bus.paso_vehiculo || expira) begin
            estado   <= ST_CERRANDO;
            conc_ent <= 1'b0;
            conc_sal <= 1'b0;
            cerrar   <= 1'b1;
            tout     <= !bus.paso_vehiculo;
`ifndef ARB_PRIO_SALIDA_EN
            ultimo   <= (estado == ST_ABIERTO_ENT) ? LANE_ENT : LANE_SAL;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_CERRANDO: estado <= ST_IDLE;
        default:     estado <= ST_IDLE;
      endcase
    end
  end

  contador_ocupacion #(
    .CAPACIDAD (CAPACIDAD),
    .CNT_W     (CNT_W)
  ) u_contador (
    .clk       (clk),
    .reset     (reset),
    .inc       (inc),
    .dec       (dec),
    .ocupacion (ocup),
    .lleno     (lleno)
  );

  assign bus.concedido_entrada = conc_ent;
  assign bus.concedido_salida  = conc_sal;
  assign bus.abrir_compuerta   = abrir;
  assign bus.cerrar_compuerta  = cerrar;
  assign bus.timeout           = tout;
  assign bus.ocupacion         = ocup;
  assign bus.lleno             = lleno;
  assign estado_dbg            = estado;
endmodule

// File: tb/tb_arbitro_compuerta.sv
// Bench for arbitro_compuerta: transaction-level model predicts grant/close events into a queue,
// a negedge monitor pops and compares them (lane, timeout, occupancy, lleno, cycle of appearance).
module tb_arbitro_compuerta;
  import arbitro_compuerta_pkg::*;

  localparam int CAP = 8;
  localparam int T   = 16;
  localparam int W   = 32;

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  estado_t estado_dbg;
  int      cyc = 0;

  arbitro_compuerta_if #(.CNT_W(4)) bus ();

  arbitro_compuerta #(
    .CAPACIDAD (CAP),
    .CNT_W     (4),
    .T_ESPERA  (T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .estado_dbg (estado_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // reference model: vehicles inside, last served lane (0 entry, 1 exit), first cycle the gate is free
  int occ = 0;
  bit ultimo = 1'b1;
  int idle_cyc = 0;

  function automatic logic [W-1:0] pack(bit kind, bit b, int o, bit ll, int c);
    return {kind, b, o[3:0], ll, c[24:0]};
  endfunction

  task automatic check(string nombre, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nombre, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] act;
    forever begin
      @(negedge clk);
      if (bus.abrir_compuerta) begin
        act = pack(1'b0, bus.concedido_salida, int'(bus.ocupacion), bus.lleno, cyc);
        check("concesion_unica", bus.concedido_entrada ^ bus.concedido_salida, 1);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL concesion_inesperada: got %h expected none", act);
        end else check("concesion", act, exp_q.pop_front());
      end
      if (bus.cerrar_compuerta) begin
        act = pack(1'b1, bus.timeout, int'(bus.ocupacion), bus.lleno, cyc);
        check("cierre_sin_concesion", {bus.concedido_entrada, bus.concedido_salida}, 0);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL cierre_inesperado: got %h expected none", act);
        end else check("cierre", act, exp_q.pop_front());
      end
      if (bus.timeout) check("timeout_con_cerrar", bus.cerrar_compuerta, 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic esperar_ciclo(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Present requests, predict the winner and the close event, then drive paso at grant offset k
  // (k >= T means no pass: the grant must expire).
  task automatic transaccion(input bit re, input bit rs, input int k);
    int cur, gc, cc;
    bit e_ok, s_ok, gana_sal, tmo;
    cur = cyc;
    bus.sol_entrada = re;
    bus.sol_salida  = rs;
    e_ok = re && (occ < CAP);
    s_ok = rs;
    if (!e_ok && !s_ok) begin
      // nothing eligible: a stray paso while idle must be ignored
      @(negedge clk); bus.paso_vehiculo = 1'b1;
      @(negedge clk); bus.paso_vehiculo = 1'b0;
      @(negedge clk);
      bus.sol_entrada = 1'b0;
      bus.sol_salida  = 1'b0;
      return;
    end
`ifdef ARB_PRIO_SALIDA_EN
    gana_sal = s_ok;
`else
    if (e_ok && s_ok) gana_sal = !ultimo;
    else              gana_sal = s_ok;
`endif
    gc = ((cur > idle_cyc) ? cur : idle_cyc) + 1;
    exp_q.push_back(pack(1'b0, gana_sal, occ, occ == CAP, gc));
    tmo = (k >= T);
    if (!tmo) begin
      if (gana_sal) occ = (occ > 0) ? occ - 1 : 0;
      else          occ = (occ < CAP) ? occ + 1 : CAP;
      cc = gc + k + 1;
    end else begin
      cc = gc + T;
    end
    ultimo = gana_sal;
    exp_q.push_back(pack(1'b1, tmo, occ, occ == CAP, cc));
    esperar_ciclo(gc);
    if ($urandom_range(0, 3) == 0) begin
      bus.sol_entrada = 1'b0;
      bus.sol_salida  = 1'b0;
    end
    if (!tmo) begin
      esperar_ciclo(gc + k);
      bus.paso_vehiculo = 1'b1;
      @(negedge clk);
      bus.paso_vehiculo = 1'b0;
    end
    esperar_ciclo(cc);
    idle_cyc = cc + 1;
  endtask

  task automatic espera_sin_concesion(input int n);
    bus.sol_entrada = 1'b1;
    bus.sol_salida  = 1'b0;
    repeat (n) @(negedge clk);
    check("lleno_bloquea_entrada", bus.concedido_entrada, 0);
    check("lleno_nivel", bus.lleno, 1);
  endtask

  task automatic comprobar_salidas_cero(string nombre);
    check(nombre, {bus.concedido_entrada, bus.concedido_salida, bus.abrir_compuerta,
                   bus.cerrar_compuerta, bus.timeout, bus.ocupacion, bus.lleno}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gc;
    bus.sol_entrada   = 1'b0;
    bus.sol_salida    = 1'b0;
    bus.paso_vehiculo = 1'b0;
    #1 comprobar_salidas_cero("reset_inicial");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_cyc = cyc;

    // first entry, pass at offset 3
    transaccion(1'b1, 1'b0, 3);

    // both lanes held: grants alternate (or exit always wins in priority build)
    repeat (4) transaccion(1'b1, 1'b1, $urandom_range(0, T - 2));

    // fill the lot by entries only
    for (int i = 0; i < 20 && occ < CAP; i++) transaccion(1'b1, 1'b0, $urandom_range(0, T - 2));
    espera_sin_concesion(20);
    transaccion(1'b1, 1'b1, 2);
    transaccion(1'b1, 1'b0, 1);

    // expiry without pass, then pass exactly on the expiry cycle
    transaccion(1'b0, 1'b1, T + 5);
    transaccion(1'b1, 1'b0, T - 1);
    transaccion(1'b0, 1'b1, T - 1);

    // random traffic
    for (int i = 0; i < 30; i++)
      transaccion(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, T + 2));

    // reset while the exit lane holds the gate
    bus.sol_entrada = 1'b0;
    bus.sol_salida  = 1'b1;
    gc = ((cyc > idle_cyc) ? cyc : idle_cyc) + 1;
    exp_q.push_back(pack(1'b0, 1'b1, occ, occ == CAP, gc));
    esperar_ciclo(gc + 3);
    check("estado_abierto_sal", estado_dbg, ST_ABIERTO_SAL);
    bus.sol_salida = 1'b0;
    #2 reset = 1'b0;
    #1 comprobar_salidas_cero("reset_en_concesion");
    repeat (2) @(negedge clk);
    comprobar_salidas_cero("reset_sostenido");
    reset = 1'b1;
    occ = 0;
    ultimo = 1'b1;
    idle_cyc = cyc;

    // first tie after reset goes to entry; then exits down to and past zero
    transaccion(1'b1, 1'b1, 2);
    transaccion(1'b0, 1'b1, 1);
    transaccion(1'b0, 1'b1, 1);

    repeat (5) @(negedge clk);
    check("cola_vacia", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // hard bound in case of a stuck run
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
